// File: rtl/e_fwd_ctrl.sv
// Execute-stage forwarding and load-use hazard controller: registered operand
// select codes for E plus a one-cycle load-use stall. Optional counters via FWD_STATS_EN.
module e_fwd_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_d_valid,
   input  logic [REG_AW-1:0] i_d_rs,
   input  logic [REG_AW-1:0] i_d_rt,
   input  logic [REG_AW-1:0] i_d_rd,
   input  logic              i_d_regwrite,
   input  logic              i_d_memread,
   input  logic              i_flush,
   output logic [1:0]        o_con_fba,
   output logic [1:0]        o_con_fbb,
   output logic              o_e_valid,
   output logic              o_stall
`ifdef FWD_STATS_EN
   ,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_fwd_cnt
`endif
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_WB  = 2'b01;

   typedef enum logic {
      ST_RUN,
      ST_STALL
   } state_e;

   if (REG_AW < 1) begin : g_reg_aw_chk
      $error("e_fwd_ctrl: REG_AW must be at least 1");
   end
   if (CNT_W < 2) begin : g_cnt_w_chk
      $error("e_fwd_ctrl: CNT_W must be at least 2");
   end

   state_e            state_q, state_d;
   logic [REG_AW-1:0] e_dst_q, e_dst_d;
   logic              e_we_q, e_we_d;
   logic              e_mr_q, e_mr_d;
   logic              e_valid_q, e_valid_d;
   logic [REG_AW-1:0] m_dst_q, m_dst_d;
   logic              m_we_q, m_we_d;
   logic [1:0]        fba_q, fba_d;
   logic [1:0]        fbb_q, fbb_d;

   logic haz;
   logic stall;
   logic advance;

   // E's producer lands in M next cycle (10); M's producer lands in W (01).
   function automatic logic [1:0] fwd_code(
      input logic [REG_AW-1:0] src,
      input logic              e_we,
      input logic [REG_AW-1:0] e_dst,
      input logic              m_we,
      input logic [REG_AW-1:0] m_dst
   );
      logic [1:0] code;
      code = SEL_RF;
      if (src != '0) begin
         if (e_we && (e_dst == src))
            code = SEL_MEM;
         else if (m_we && (m_dst == src))
            code = SEL_WB;
      end
      return code;
   endfunction

   always_comb begin
      haz = i_d_valid && e_valid_q && e_mr_q && e_we_q && (e_dst_q != '0) &&
            ((e_dst_q == i_d_rs) || (e_dst_q == i_d_rt));
      stall   = haz && !i_flush && (state_q == ST_RUN);
      advance = i_d_valid && !i_flush && !stall;
   end

   assign o_stall = stall;

   always_comb begin
      // NOTE: every _d gets a default first so no path through this block leaves a latch.
      state_d   = ST_RUN;
      m_dst_d   = e_dst_q;
      m_we_d    = e_we_q;
      e_dst_d   = '0;
      e_we_d    = 1'b0;
      e_mr_d    = 1'b0;
      e_valid_d = 1'b0;
      fba_d     = SEL_RF;
      fbb_d     = SEL_RF;

      if (stall)
         state_d = ST_STALL;

      if (advance) begin
         e_dst_d   = i_d_rd;
         e_we_d    = i_d_regwrite;
         e_mr_d    = i_d_memread;
         e_valid_d = 1'b1;
         fba_d     = fwd_code(i_d_rs, e_we_q, e_dst_q, m_we_q, m_dst_q);
         fbb_d     = fwd_code(i_d_rt, e_we_q, e_dst_q, m_we_q, m_dst_q);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_RUN;
         e_dst_q   <= '0;
         e_we_q    <= 1'b0;
         e_mr_q    <= 1'b0;
         e_valid_q <= 1'b0;
         m_dst_q   <= '0;
         m_we_q    <= 1'b0;
         fba_q     <= SEL_RF;
         fbb_q     <= SEL_RF;
      end else begin
         state_q   <= state_d;
         e_dst_q   <= e_dst_d;
         e_we_q    <= e_we_d;
         e_mr_q    <= e_mr_d;
         e_valid_q <= e_valid_d;
         m_dst_q   <= m_dst_d;
         m_we_q    <= m_we_d;
         fba_q     <= fba_d;
         fbb_q     <= fbb_d;
      end
   end

   assign o_con_fba = fba_q;
   assign o_con_fbb = fbb_q;
   assign o_e_valid = e_valid_q;

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
   logic [1:0]       fwd_inc;
   logic [CNT_W:0]   fwd_sum;

   always_comb begin
      fwd_inc = {1'b0, fba_d != SEL_RF} + {1'b0, fbb_d != SEL_RF};
      fwd_sum = {1'b0, fwd_cnt_q} + (CNT_W + 1)'(fwd_inc);
      fwd_cnt_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign o_stall_cnt = stall_cnt_q;
   assign o_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
